// File: rtl/ctrl_event_unit_pkg.sv
// Shared definitions for the control-event unit.
//   - FSM state encoding
//   - AQ sub-op codes (read side and write side share the 2-bit field)
//   - POP response word layout, plus a helper that builds that word
package ctrl_event_unit_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Read sub-ops
  localparam logic [1:0] OP_POP     = 2'd0;
  localparam logic [1:0] OP_STATUS  = 2'd1;
  // Write sub-ops
  localparam logic [1:0] OP_CLRMASK = 2'd0;
  localparam logic [1:0] OP_CLROVF  = 2'd1;

  // POP response word fields
  localparam int POP_VALID_BIT = 31;
  localparam int POP_OVF_BIT   = 30;
  localparam int POP_SRC_LSB   = 4;
  localparam int POP_TYPE_LSB  = 0;

  function automatic logic [31:0] pop_word(input logic       ovf,
                                           input logic [3:0] src,
                                           input logic [3:0] typ);
    logic [31:0] w;
    w                         = '0;
    w[POP_VALID_BIT]          = 1'b1;
    w[POP_OVF_BIT]            = ovf;
    w[POP_SRC_LSB +: 4]       = src;
    w[POP_TYPE_LSB +: 4]      = typ;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_event_unit_if.sv
// Local-I/O AQ/WQ/RQ handshake between the CPU (master) and the device (slave).
//   aq[16:3]  AQ head; only aq[4:3] (sub-op) matters to this device
//   read      AQ request is a read
//   selCtrl   device addressed by the AQ head
//   wq        write-queue data
//   rwq       device pops the write queue
//   rqCtrl    read-queue data (zero whenever wrq is low)
//   wrq       device writes the read queue
//   done      operation finished, AQ head is popped
//
// Handshake: selCtrl is level-sampled by the device while idle; the device
// answers in exactly the following cycle with done plus either wrq (reads)
// or rwq (writes). There is no back-pressure; the master must keep wq valid
// through the response cycle and drop selCtrl for at least the cycle after
// done unless it wants a further operation.
interface ctrl_event_unit_if;
  logic [16:3] aq;
  logic        read;
  logic        selCtrl;
  logic [31:0] wq;
  logic        rwq;
  logic [31:0] rqCtrl;
  logic        wrq;
  logic        done;

  modport master (
    output aq, read, selCtrl, wq,
    input  rwq, rqCtrl, wrq, done
  );

  modport slave (
    input  aq, read, selCtrl, wq,
    output rwq, rqCtrl, wrq, done
  );
endinterface

// File: rtl/ctrl_event_fifo.sv
// DEPTH x 8 register FIFO with a combinational head output.
// Ports:
//   clock, reset      clock, asynchronous active-low reset
//   push, din         write din at the tail (caller guarantees room, or a
//                     simultaneous pop when full)
//   pop               drop the head (caller guarantees non-empty)
//   head              current head entry, valid when !empty
//   full, empty       status flags
//   occupancy         entries held, 0..DEPTH
module ctrl_event_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage needs no reset; validity is tracked by the occupancy counter.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + (AW+1)'(1);
        2'b01:   occupancy <= occupancy - (AW+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (occupancy == '0);
  assign full  = (occupancy == FULL_CNT);

endmodule

// File: rtl/ctrl_event_unit.sv
// Control-event unit: queues zero-length control messages from the
// messenger, tracks a per-type pending mask and counts overflow drops.
// The CPU drains and inspects it through the local-I/O handshake.
// Ports:
//   clock, reset           clock, asynchronous active-low reset
//   ctrlValid/Type/Src     one-cycle control message strobe and payload
//   lio                    AQ/WQ/RQ handshake (slave side)
//   eventPending           FIFO non-empty
//   dbg_state              current FSM state
module ctrl_event_unit
  import ctrl_event_unit_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ctrlValid,
  input  logic [3:0]             ctrlType,
  input  logic [3:0]             ctrlSrc,
  ctrl_event_unit_if.slave       lio,
  output logic                   eventPending,
  output state_e                 dbg_state
);

  state_e              state;
  logic                op_read;
  logic [1:0]          op_sub;
  logic [15:0]         pend_mask;
  logic                ovf;
  logic [DROP_W-1:0]   drop_cnt;

  logic [7:0]          head;
  logic                full;
  logic                empty;
  logic [$clog2(DEPTH):0] occupancy;

  logic in_resp, rd_pop, rd_status, wr_clrmask, wr_clrovf;
  logic do_pop, do_push, do_drop;
  logic [15:0] clr_bits, set_bits;

  assign in_resp    = (state == ST_RESP);
  assign rd_pop     = in_resp &&  op_read && (op_sub == OP_POP);
  assign rd_status  = in_resp &&  op_read && (op_sub == OP_STATUS);
  assign wr_clrmask = in_resp && !op_read && (op_sub == OP_CLRMASK);
  assign wr_clrovf  = in_resp && !op_read && (op_sub == OP_CLROVF);

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_pop  = rd_pop && !empty;
  assign do_push = ctrlValid && (!full || do_pop);
  assign do_drop = ctrlValid && full && !do_pop;

  // Set is OR-ed after the clear so a coincident arrival keeps its bit.
  assign clr_bits = wr_clrmask ? lio.wq[15:0] : 16'h0000;
  assign set_bits = ctrlValid ? (16'h0001 << ctrlType) : 16'h0000;

  ctrl_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (do_push),
    .din       ({ctrlSrc, ctrlType}),
    .pop       (do_pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      op_read   <= 1'b0;
      op_sub    <= 2'b00;
      pend_mask <= '0;
      ovf       <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lio.selCtrl) begin
            state   <= ST_RESP;
            op_read <= lio.read;
            op_sub  <= lio.aq[4:3];
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      pend_mask <= (pend_mask & ~clr_bits) | set_bits;

      // Clearing takes priority over a coincident drop.
      if (wr_clrovf) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end else if (do_drop) begin
        ovf <= 1'b1;
        if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

  assign lio.done = in_resp;
  assign lio.wrq  = in_resp &&  op_read;
  assign lio.rwq  = in_resp && !op_read;

  always_comb begin
    lio.rqCtrl = '0;
    if (rd_pop && !empty)
      lio.rqCtrl = pop_word(ovf, head[7:4], head[3:0]);
    else if (rd_status)
      lio.rqCtrl = {8'(drop_cnt), 8'(occupancy), pend_mask};
  end

  assign eventPending = !empty;
  assign dbg_state    = state;

  // Address and write-data bits this device does not decode.
  logic unused_bits;
  assign unused_bits = ^{lio.aq[16:5], lio.wq[31:16]};

endmodule
